param_processor: RTL

PARAM_PROCESSOR -- requirements
Module: param_processor

---
 rtl/proc_pkg.sv | 38 +++
 rtl/instr_fifo.sv | 60 ++++++
 rtl/param_processor.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared opcode/state encodings and width-derivation helpers for param_processor.
package proc_pkg;

  localparam int OPCODE_W = 32'sd3;

  typedef enum logic [2:0] {
    OP_STORE = 3'b000,
    OP_LOAD  = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_NOP   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ALU words carry three register fields; memory words carry one register and an address.
  function automatic int instr_w_f(input int ra_w, input int da_w);
    return OPCODE_W + max_f(32'sd3 * ra_w, ra_w + da_w);
  endfunction

  function automatic int count_w_f(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue: circular buffer with occupancy count; a push while full is refused.
module instr_fifo
  import proc_pkg::*;
#(
  parameter int WIDTH = 32'sd12,
  parameter int DEPTH = 32'sd4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = count_w_f(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 32'sd0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/param_processor.sv
// Small multi-cycle processor: queued instructions run FETCH/EXEC/WB against an
// inline register file, ALU and data memory.
module param_processor
  import proc_pkg::*;
#(
  parameter int DATA_W     = 32'sd4,
  parameter int NREGS      = 32'sd8,
  parameter int DMEM_DEPTH = 32'sd16,
  parameter int IQ_DEPTH   = 32'sd4,
  localparam int RA_W    = $clog2(NREGS),
  localparam int DA_W    = $clog2(DMEM_DEPTH),
  localparam int INSTR_W = instr_w_f(RA_W, DA_W),
  localparam int CNT_W   = count_w_f(IQ_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               run_mode,
  input  logic               step,
  input  logic [RA_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               result_valid,
  output logic [DATA_W-1:0]  result_data,
  output logic [RA_W-1:0]    result_reg,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   iq_count
);

  logic [INSTR_W-1:0] fifo_dout_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               pop_s;

  state_t             state_r;
  state_t             state_next_s;
  logic               busy_r;
  logic               halted_r;
  logic [INSTR_W-1:0] ir_r;

  logic [DATA_W-1:0]  regs_r [NREGS];
  logic [DATA_W-1:0]  dmem_r [DMEM_DEPTH];

  logic               result_valid_r;
  logic [DATA_W-1:0]  result_data_r;
  logic [RA_W-1:0]    result_reg_r;
  logic               zero_r;
  logic               carry_r;

  opcode_t            op_s;
  logic [RA_W-1:0]    dst_s;
  logic [RA_W-1:0]    src1_s;
  logic [RA_W-1:0]    src2_s;
  logic [DA_W-1:0]    addr_s;
  logic [DATA_W-1:0]  opa_s;
  logic [DATA_W-1:0]  opb_s;
  logic [DATA_W:0]    sum_s;
  logic [DATA_W:0]    diff_s;
  logic [DATA_W-1:0]  alu_res_s;
  logic               alu_carry_s;
  logic               is_alu_s;
  logic               writes_reg_s;

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk   (clk),
    .reset (reset),
    .push  (instr_valid),
    .din   (instr),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign instr_ready  = !fifo_full_s;
  assign iq_count     = fifo_count_s;
  assign busy         = busy_r;
  assign halted       = halted_r;
  assign result_valid = result_valid_r;
  assign result_data  = result_data_r;
  assign result_reg   = result_reg_r;
  assign zero_flag    = zero_r;
  assign carry_flag   = carry_r;
  assign dbg_data     = regs_r[dbg_addr];

  // Field decode; memory ops reuse the first register field and place the address after it.
  assign op_s   = opcode_t'(ir_r[INSTR_W-1 -: OPCODE_W]);
  assign dst_s  = ir_r[INSTR_W-OPCODE_W-1 -: RA_W];
  assign src1_s = ir_r[INSTR_W-OPCODE_W-RA_W-1 -: RA_W];
  assign src2_s = ir_r[INSTR_W-OPCODE_W-2*RA_W-1 -: RA_W];
  assign addr_s = ir_r[INSTR_W-OPCODE_W-RA_W-1 -: DA_W];

  assign opa_s  = regs_r[src1_s];
  assign opb_s  = regs_r[src2_s];
  assign sum_s  = {1'b0, opa_s} + {1'b0, opb_s};
  assign diff_s = {1'b0, opa_s} - {1'b0, opb_s};

  assign is_alu_s     = (op_s == OP_ADD) || (op_s == OP_SUB) || (op_s == OP_AND) || (op_s == OP_OR);
  assign writes_reg_s = is_alu_s || (op_s == OP_LOAD);

  // The extra top bit of diff_s is the borrow for SUB.
  always_comb begin
    alu_res_s   = '0;
    alu_carry_s = 1'b0;
    case (op_s)
      OP_ADD: begin
        alu_res_s   = sum_s[DATA_W-1:0];
        alu_carry_s = sum_s[DATA_W];
      end
      OP_SUB: begin
        alu_res_s   = diff_s[DATA_W-1:0];
        alu_carry_s = diff_s[DATA_W];
      end
      OP_AND:  alu_res_s = opa_s & opb_s;
      OP_OR:   alu_res_s = opa_s | opb_s;
      default: alu_res_s = '0;
    endcase
  end

  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s && (run_mode || step)) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        pop_s        = 1'b1;
        state_next_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (op_s == OP_HALT) begin
          state_next_s = ST_HALTED;
        end else begin
          state_next_s = ST_WB;
        end
      end
      ST_WB: begin
        if (run_mode && !fifo_empty_s) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_HALTED: state_next_s = ST_HALTED;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
      ir_r     <= '0;
    end else begin
      state_r  <= state_next_s;
      busy_r   <= (state_next_s == ST_FETCH) || (state_next_s == ST_EXEC) || (state_next_s == ST_WB);
      halted_r <= (state_next_s == ST_HALTED);
      if (pop_s) begin
        ir_r <= fifo_dout_s;
      end
    end
  end

  // EXEC captures the result and flags (visible during WB); the register commits leaving WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 32'sd0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
      for (int i = 32'sd0; i < DMEM_DEPTH; i++) begin
        dmem_r[i] <= '0;
      end
      result_valid_r <= 1'b0;
      result_data_r  <= '0;
      result_reg_r   <= '0;
      zero_r         <= 1'b0;
      carry_r        <= 1'b0;
    end else begin
      result_valid_r <= (state_r == ST_EXEC) && writes_reg_s;
      if (state_r == ST_EXEC) begin
        if (op_s == OP_STORE) begin
          dmem_r[addr_s] <= regs_r[dst_s];
        end
        if (writes_reg_s) begin
          result_data_r <= (op_s == OP_LOAD) ? dmem_r[addr_s] : alu_res_s;
          result_reg_r  <= dst_s;
        end
        if (is_alu_s) begin
          zero_r  <= (alu_res_s == '0);
          carry_r <= alu_carry_s;
        end
      end
      if ((state_r == ST_WB) && result_valid_r) begin
        regs_r[dst_s] <= result_data_r;
      end
    end
  end

endmodule
